// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit instruction-memory and decode-side handshake bundle
//
// Groups the two handshakes of the fetch unit:
//   imem side   : imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in
//   decode side : instr/instr_valid/pc/pc_plus4 out, instr_ready/pc_sel/pc_target in
// master = the fetch unit, slave = memory plus core datapath.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_sel;
  logic [XLEN-1:0] pc_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr, instr_valid, pc, pc_plus4,
    input  instr_ready, pc_sel, pc_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr, instr_valid, pc, pc_plus4,
    output instr_ready, pc_sel, pc_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch front end with misaligned-target halt
//
// Owns the PC, fetches one word at a time over req/gnt/rvalid and holds it for
// decode over valid/ready. On retire the next PC is pc_target (pc_sel=1) or
// pc+4; a target that is not word aligned stops fetch until reset.
//
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   bus          instr_fetch_unit_if.master (imem handshake + decode handshake)
//   misaligned   sticky fetch-fault flag
//   fault_addr   offending next-PC value captured with the fault
//   instret      64-bit retire count
//
// Optional feature: define FETCH_INSTRET_EN to build the instret counter;
// without it instret is constant zero.
//
// RESET_PC must be word aligned.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus,
  output logic               misaligned,
  output logic [XLEN-1:0]    fault_addr,
  output logic [63:0]        instret
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    VALID,
    FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misaligned_d;
  logic [XLEN-1:0] fault_addr_d;
  logic [XLEN-1:0] next_pc;
  logic            retire;

  assign bus.pc_plus4 = pc_q + XLEN'(4);
  assign next_pc      = bus.pc_sel ? bus.pc_target : bus.pc_plus4;
  assign retire       = (state_q == VALID) && bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      misaligned <= 1'b0;
      fault_addr <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misaligned <= misaligned_d;
      fault_addr <= fault_addr_d;
    end
  end

  // gnt is only looked at in REQ and rvalid only in WAIT, so a same-cycle
  // gnt+rvalid or a stale rvalid after reset never reaches instr.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned;
    fault_addr_d = fault_addr;
    case (state_q)
      REQ: begin
        if (bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (retire) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            // pc keeps the faulting instruction's address for debug
            misaligned_d = 1'b1;
            fault_addr_d = next_pc;
            state_d      = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // state_q is forced to REQ while reset is held; gating with rst_n keeps
  // the request low during reset itself.
  assign bus.imem_req    = rst_n && (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;

`ifdef FETCH_INSTRET_EN
  // counts the faulting retire too; wraps naturally at 2^64
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard testbench for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        misaligned;
  logic [31:0] fault_addr;
  logic [63:0] instret;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .misaligned (misaligned),
    .fault_addr (fault_addr),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // memory model: acts 2 time units after each rising edge
  logic        mem_auto = 1'b1;
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        outstanding = 1'b0;
  int          gwait = 0;
  int          rv_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] req_log[$];

  assign bus.imem_gnt    = mem_auto ? mem_gnt    : man_gnt;
  assign bus.imem_rvalid = mem_auto ? mem_rvalid : man_rvalid;
  assign bus.imem_rdata  = mem_auto ? mem_rdata  : man_rdata;

  always @(posedge clk) begin
    #2;
    if (!rst_n || !mem_auto) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; outstanding = 1'b0; gwait = 0; rv_cnt = 0;
    end else begin
      mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid  = 1'b1;
          mem_rdata   = mem_word(pend_addr);
          outstanding = 1'b0;
        end
      end
      mem_gnt = 1'b0;
      if (bus.imem_req && !outstanding) begin
        if (gwait < gnt_delay) gwait++;
        else begin
          mem_gnt = 1'b1; gwait = 0; outstanding = 1'b1;
          pend_addr = bus.imem_addr; rv_cnt = rv_delay + 1;
          req_log.push_back(bus.imem_addr);
        end
      end
    end
  end

  // retire monitor
  logic [31:0] obs_pc[$], obs_instr[$], obs_pcp4[$];
  int          obs_cyc[$];
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      obs_pc.push_back(bus.pc);
      obs_instr.push_back(bus.instr);
      obs_pcp4.push_back(bus.pc_plus4);
      obs_cyc.push_back(cyc);
    end
  end

  int          n_asserts = 0;
  int          n_fail = 0;
  int          obs_rd = 0;
  int          req_rd = 0;
  int          retired = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret(input int r);
`ifdef FETCH_INSTRET_EN
    return 64'(r);
`else
    return 64'(0 * r);
`endif
  endfunction

  task automatic retire_n(input int n, input logic sel, input logic [31:0] tgt);
    int done = 0;
    int budget = 200;
    @(posedge clk); #1;
    bus.pc_sel = sel; bus.pc_target = tgt; bus.instr_ready = 1'b1;
    while (done < n && budget > 0) begin
      @(negedge clk); budget--;
      if (bus.instr_valid) done++;
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0; bus.pc_sel = 1'b0;
    retired += done;
    check("retire_count", 64'(done), 64'(n));
  endtask

  task automatic drain(input int n);
    logic [31:0] e, e4;
    check("sb_obs_count", 64'(obs_pc.size() - obs_rd), 64'(n));
    for (int i = 0; i < n && obs_rd < obs_pc.size() && exp_q.size() > 0; i++) begin
      e  = exp_q.pop_front();
      e4 = e + 32'd4;
      check("sb_pc", obs_pc[obs_rd], e);
      check("sb_instr", obs_instr[obs_rd], mem_word(e));
      check("sb_pc_plus4", obs_pcp4[obs_rd], e4);
      obs_rd++;
    end
  endtask

  task automatic wait_valid();
    int i = 0;
    @(negedge clk);
    while (!bus.instr_valid && i < 100) begin @(negedge clk); i++; end
    check("wait_valid", bus.instr_valid, 1);
  endtask

  task automatic check_req(input logic [31:0] a);
    check("req_present", req_log.size() > req_rd, 1);
    if (req_log.size() > req_rd) begin
      check("req_addr", req_log[req_rd], a);
      req_rd++;
    end
  endtask

  initial begin
    int base, req_cyc, w;
    logic addr_ok, prev_rv;
    bus.instr_ready = 1'b0; bus.pc_sel = 1'b0; bus.pc_target = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_pc", bus.pc, RST_PC);
    check("rst_instr", bus.instr, 32'h13);
    check("rst_misaligned", misaligned, 0);
    check("rst_fault_addr", fault_addr, 0);
    check("rst_instret", instret, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // sequential fetch, zero-wait memory
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    base = obs_rd;
    retire_n(3, 1'b0, 32'h0);
    if (obs_cyc.size() >= base + 3) begin
      check("t1_spacing_a", 64'(obs_cyc[base+1] - obs_cyc[base]), 3);
      check("t1_spacing_b", 64'(obs_cyc[base+2] - obs_cyc[base+1]), 3);
    end
    drain(3);
    wait_valid();
    check_req(32'h100); check_req(32'h104); check_req(32'h108); check_req(32'h10C);
    check("t1_instret", instret, exp_instret(retired));

    // grant stall 4 cycles, rvalid delayed 2 cycles
    gnt_delay = 4; rv_delay = 2;
    exp_q.push_back(32'h10C);
    retire_n(1, 1'b0, 32'h0);
    drain(1);
    req_cyc = 0; addr_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        req_cyc++;
        if (bus.imem_addr !== 32'h110) addr_ok = 1'b0;
      end else if (req_cyc > 0) break;
    end
    check("t2_req_cycles", 64'(req_cyc), 5);
    check("t2_addr_stable", addr_ok, 1);
    w = 0; prev_rv = 1'b0;
    for (int i = 0; i < 50 && !bus.instr_valid; i++) begin
      w++; prev_rv = bus.imem_rvalid; @(negedge clk);
    end
    check("t2_wait_cycles", 64'(w), 3);
    check("t2_valid_after_rvalid", prev_rv, 1);
    check("t2_no_dup_req", 64'(req_log.size() - req_rd), 1);
    check_req(32'h110);
    gnt_delay = 0; rv_delay = 0;

    // branch to 0x200, then pc_sel without ready, then branch to 0x40
    exp_q.push_back(32'h110);
    retire_n(1, 1'b1, 32'h200);
    drain(1);
    wait_valid();
    check_req(32'h200);
    check("t3_pc_200", bus.pc, 32'h200);
    @(posedge clk); #1 bus.pc_sel = 1'b1; bus.pc_target = 32'h80;
    repeat (5) @(negedge clk);
    check("t3_noready_pc", bus.pc, 32'h200);
    check("t3_noready_valid", bus.instr_valid, 1);
    check("t3_noready_req", bus.imem_req, 0);
    exp_q.push_back(32'h200);
    retire_n(1, 1'b1, 32'h40);
    drain(1);
    wait_valid();
    check_req(32'h40);
    check("t3_pc_40", bus.pc, 32'h40);

    // wrap-around from 0xFFFF_FFFC
    exp_q.push_back(32'h40);
    retire_n(1, 1'b1, 32'hFFFF_FFFC);
    drain(1);
    wait_valid();
    check_req(32'hFFFF_FFFC);
    check("t4_pc_plus4_wrap", bus.pc_plus4, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    retire_n(1, 1'b0, 32'h0);
    drain(1);
    wait_valid();
    check_req(32'h0);
    check("t4_pc_zero", bus.pc, 32'h0);
    check("t4_no_fault", misaligned, 0);

    // misaligned target
    exp_q.push_back(32'h0);
    retire_n(1, 1'b1, 32'h302);
    drain(1);
    @(negedge clk);
    check("t5_misaligned", misaligned, 1);
    check("t5_fault_addr", fault_addr, 32'h302);
    check("t5_pc_hold", bus.pc, 32'h0);
    @(posedge clk); #1 bus.instr_ready = 1'b1; bus.pc_sel = 1'b1; bus.pc_target = 32'h400;
    req_cyc = 0; w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) req_cyc++;
      if (bus.instr_valid) w++;
    end
    check("t5_req_idle", 64'(req_cyc), 0);
    check("t5_valid_idle", 64'(w), 0);
    check("t5_fault_addr_hold", fault_addr, 32'h302);
    check("t5_instret", instret, exp_instret(retired));
    @(posedge clk); #1 bus.instr_ready = 1'b0; bus.pc_sel = 1'b0; rst_n = 1'b0; mem_auto = 1'b0;
    retired = 0;
    @(negedge clk);
    check("t5_rst_misaligned", misaligned, 0);
    check("t5_rst_fault_addr", fault_addr, 0);
    check("t5_rst_pc", bus.pc, RST_PC);
    check("t5_rst_instret", instret, 0);
    check("t5_rst_req", bus.imem_req, 0);

    // reset while in WAIT, then a stale rvalid
    @(posedge clk); #1 rst_n = 1'b1; man_gnt = 1'b1;
    @(posedge clk); #1 man_gnt = 1'b0;
    @(negedge clk);
    check("t6_in_wait", bus.imem_req, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_req", bus.imem_req, 0);
    @(posedge clk); #1 rst_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 man_rvalid = 1'b0;
    @(negedge clk);
    check("t6_stale_req", bus.imem_req, 1);
    check("t6_stale_addr", bus.imem_addr, RST_PC);
    check("t6_stale_valid", bus.instr_valid, 0);
    check("t6_stale_instr", bus.instr, 32'h13);
    @(posedge clk); #1 mem_auto = 1'b1;
    exp_q.push_back(32'h100);
    retire_n(1, 1'b0, 32'h0);
    drain(1);
    check_req(32'h100);
    check("t6_instret_1", instret, exp_instret(retired));
    exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C); exp_q.push_back(32'h110);
    retire_n(4, 1'b0, 32'h0);
    drain(4);
    check("t6_instret_5", instret, exp_instret(retired));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Single-cycle core front end; sits directly upstream of the instruction decode/control block.
- Owns the PC register, fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake, and presents it with a valid/ready handshake.
- Consumes the next-PC decision (pc_sel, pc_target) when the current instruction is retired.
- Detects misaligned jump/branch targets and halts fetch.

Parameters:
- XLEN, 32, address/data width; only 32 is supported.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  fetched instruction word.
- instr  out  XLEN  held instruction to decode (opcode = instr[6:0], funct3 = instr[14:12], funct7b5 = instr[30]).
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  core executes/retires instr this cycle.
- pc  out  XLEN  address of instr.
- pc_plus4  out  XLEN  pc + 4, modulo 2^32.
- pc_sel  in  1  1 = take pc_target; sampled only on the retire handshake.
- pc_target  in  XLEN  branch/jump target from the datapath.
- misaligned  out  1  sticky fetch-fault flag.
- fault_addr  out  XLEN  offending target address.
- instret  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values (async assert, sync deassert by the system):
  - state = REQ, pc = RESET_PC, instr = 32'h0000_0013 (NOP).
  - instr_valid = 0, misaligned = 0, fault_addr = 0, instret = 0.
  - imem_req = 0 while rst_n is low.
- FSM states: REQ, WAIT, VALID, FAULT.
- REQ:
  - imem_req = 1, imem_addr = pc.
  - Stay in REQ until imem_gnt = 1, then go to WAIT.
  - imem_addr and imem_req are stable while waiting for the grant.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid: instr <= imem_rdata, go to VALID.
  - The earliest rvalid is the cycle after gnt. rvalid in the same cycle as gnt is a protocol error and is ignored.
- VALID:
  - instr_valid = 1; instr and pc are held stable until the handshake.
  - Handshake = instr_valid & instr_ready. On the handshake, next = pc_sel ? pc_target : pc_plus4.
  - If next[1:0] == 0: pc <= next, instr_valid <= 0, go to REQ.
  - If next[1:0] != 0: misaligned <= 1, fault_addr <= next, instr_valid <= 0, pc unchanged, go to FAULT.
- FAULT:
  - Terminal until reset; imem_req = 0, instr_valid = 0.
  - All handshake inputs are ignored.
- Latency:
  - Minimum 3 cycles per instruction (REQ, WAIT, VALID) with zero-wait gnt and 1-cycle rvalid.
  - Each gnt stall or rvalid delay adds 1 cycle.
- Ignored inputs:
  - imem_gnt outside REQ.
  - imem_rvalid outside WAIT.
  - instr_ready outside VALID.
- Wrap-around: pc = 32'hFFFF_FFFC with pc_sel = 0 gives next = 32'h0000_0000 (legal, no fault).
- Reset mid-transaction: the FSM returns to REQ at RESET_PC. A stale rvalid arriving afterwards in REQ is dropped. The memory side must tolerate the abandoned request.
- pc_plus4 is combinational from pc. No other output depends combinationally on inputs, except that imem_req/imem_addr are state-decoded only.

Optional Feature:
- Macro FETCH_INSTRET_EN.
- Defined:
  - instret is a 64-bit counter, +1 on every retire handshake, including the one that causes FAULT.
  - Wraps from 2^64-1 to 0.
  - Cleared only by reset.
- Undefined: instret is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset with RESET_PC = 32'h100, zero-wait memory, instr_ready held 1, pc_sel = 0 -> addresses 0x100, 0x104, 0x108 requested. instr_valid pulses every 3rd cycle. First instr matches memory word at 0x100.
- imem_gnt withheld 4 cycles, then rvalid delayed 2 cycles -> imem_addr stable throughout; instr_valid rises exactly 1 cycle after rvalid; no duplicate request.
- At pc = 0x200, instr_ready = 1, pc_sel = 1, pc_target = 0x40 -> next request address 0x40; pc_sel = 1 while instr_ready = 0 has no effect.
- pc_target = 0x302 with pc_sel = 1 on handshake -> misaligned = 1, fault_addr = 0x302, pc holds, imem_req stays 0 for 20 cycles; rst_n pulse clears everything.
- pc = 32'hFFFF_FFFC, pc_sel = 0 -> next fetch at 0x0, pc_plus4 was 0x0, misaligned stays 0.
- rst_n asserted in WAIT, then stale rvalid after release -> dropped; fetch restarts at RESET_PC. With FETCH_INSTRET_EN: 5 retires -> instret = 5; after reset -> 0.
